// File: rtl/ps2_key_rx.sv
// ps2_key_rx -- PS/2 keyboard receive path.
//
// Decodes 11-bit PS/2 device-to-host frames (start, 8 data LSB first,
// odd parity, stop) from the raw pad lines. It folds the E0 (extended)
// and F0 (break) prefix bytes into the following scan code, and it
// reports one key event per strobe.
//
// Parameters
//   FILTER  : cycles a synchronized ps2Clk level must hold before it is accepted
//   TIMEOUT : cycles without an accepted falling edge before a partial frame aborts
//
// Ports
//   clock    in   system clock, all state on its rising edge
//   reset    in   asynchronous, active-low reset
//   ps2Clk   in   raw PS/2 clock line (asynchronous)
//   ps2Data  in   raw PS/2 data line (asynchronous)
//   strobe   out  one-cycle pulse: new key event on code/pressed/extended
//   pressed  out  1 = make, 0 = break (held until the next strobe)
//   code     out  scan code (held until the next strobe)
//   extended out  event was preceded by E0 (held until the next strobe)
//   error    out  one-cycle pulse on a parity or stop-bit failure
module ps2_key_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       strobe,
    output logic       pressed,
    output logic [7:0] code,
    output logic       extended,
    output logic       error
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FW-1:0] FILTER_LAST = FW'(FILTER - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchronizers and clock glitch filter
    logic          clk_meta_reg, clk_sync_reg;
    logic          data_meta_reg, data_sync_reg;
    logic          filt_clk_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          fall_edge;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_meta_reg  <= 1'b1;
            clk_sync_reg  <= 1'b1;
            data_meta_reg <= 1'b1;
            data_sync_reg <= 1'b1;
            filt_clk_reg  <= 1'b1;
            filt_cnt_reg  <= '0;
        end else begin
            clk_meta_reg  <= ps2Clk;
            clk_sync_reg  <= clk_meta_reg;
            data_meta_reg <= ps2Data;
            data_sync_reg <= data_meta_reg;
            // Count consecutive cycles the synchronized level differs from the
            // accepted one; any return to the accepted level restarts the count.
            if (clk_sync_reg == filt_clk_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FILTER_LAST) begin
                filt_clk_reg <= clk_sync_reg;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    // High in the cycle where the filtered clock is about to go 1 -> 0.
    assign fall_edge = filt_clk_reg & ~clk_sync_reg & (filt_cnt_reg == FILTER_LAST);

    // Frame FSM and event registers
    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_reg, parity_next;
    logic          ext_reg, ext_next;
    logic          brk_reg, brk_next;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic          strobe_reg, strobe_next;
    logic          error_reg, error_next;
    logic [7:0]    code_reg, code_next;
    logic          pressed_reg, pressed_next;
    logic          extended_reg, extended_next;
    logic          frame_ok;
    logic          byte_ignored;

    // Stop bit high and odd parity across data plus parity bit.
    assign frame_ok = data_sync_reg & (^{shift_reg, parity_reg});

    // Acknowledge / BAT / echo / resend / error bytes carry no key event.
    always_comb begin
        byte_ignored = 1'b0;
        case (shift_reg)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: byte_ignored = 1'b1;
            default:                                  byte_ignored = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            ext_reg      <= 1'b0;
            brk_reg      <= 1'b0;
            tmo_reg      <= '0;
            strobe_reg   <= 1'b0;
            error_reg    <= 1'b0;
            code_reg     <= '0;
            pressed_reg  <= 1'b0;
            extended_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            ext_reg      <= ext_next;
            brk_reg      <= brk_next;
            tmo_reg      <= tmo_next;
            strobe_reg   <= strobe_next;
            error_reg    <= error_next;
            code_reg     <= code_next;
            pressed_reg  <= pressed_next;
            extended_reg <= extended_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        ext_next      = ext_reg;
        brk_next      = brk_reg;
        tmo_next      = '0;
        strobe_next   = 1'b0;
        error_next    = 1'b0;
        code_next     = code_reg;
        pressed_next  = pressed_reg;
        extended_next = extended_reg;

        // Inactivity watchdog inside a frame. An edge always wins over an
        // expiring count, so the timeout path only runs without an edge.
        if (state_reg != IDLE) begin
            if (fall_edge) begin
                tmo_next = '0;
            end else if (tmo_reg == TMO_LAST) begin
                tmo_next   = '0;
                state_next = IDLE;
            end else begin
                tmo_next = tmo_reg + 1'b1;
            end
        end

        case (state_reg)
            IDLE: begin
                if (fall_edge && !data_sync_reg) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (fall_edge) begin
                    shift_next = {data_sync_reg, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (fall_edge) begin
                    parity_next = data_sync_reg;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall_edge) begin
                    state_next = IDLE;
                    if (!frame_ok) begin
                        error_next = 1'b1;
                    end else if (shift_reg == 8'hE0) begin
                        ext_next = 1'b1;
                    end else if (shift_reg == 8'hF0) begin
                        brk_next = 1'b1;
                    end else if (byte_ignored) begin
                        ext_next = 1'b0;
                        brk_next = 1'b0;
                    end else begin
                        strobe_next   = 1'b1;
                        code_next     = shift_reg;
                        pressed_next  = ~brk_reg;
                        extended_next = ext_reg;
                        ext_next      = 1'b0;
                        brk_next      = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign strobe   = strobe_reg;
    assign error    = error_reg;
    assign code     = code_reg;
    assign pressed  = pressed_reg;
    assign extended = extended_reg;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx -- directed and randomized frames against a key-event model.
module tb_ps2_key_rx;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic       clock;
    logic       reset;
    logic       ps2Clk;
    logic       ps2Data;
    logic       strobe;
    logic       pressed;
    logic [7:0] code;
    logic       extended;
    logic       error;

    ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2Clk   (ps2Clk),
        .ps2Data  (ps2Data),
        .strobe   (strobe),
        .pressed  (pressed),
        .code     (code),
        .extended (extended),
        .error    (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Activity monitor
    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_strobe = 0;
    int n_err    = 0;
    int strobe_cyc = 0;
    int fall_cyc   = 0;
    bit wide = 0;
    bit both = 0;
    bit prev_strobe = 0;
    bit prev_err    = 0;

    always @(negedge clock) begin
        if (strobe === 1'b1) begin
            n_strobe++;
            strobe_cyc = cyc;
            if (prev_strobe) wide = 1;
        end
        if (error === 1'b1) begin
            n_err++;
            if (prev_err) wide = 1;
        end
        if (strobe === 1'b1 && error === 1'b1) both = 1;
        prev_strobe = (strobe === 1'b1);
        prev_err    = (error === 1'b1);
    end

    // Reference model: key events derived from the byte stream
    bit         m_ext = 0;
    bit         m_brk = 0;
    logic [7:0] m_code = 8'h00;
    bit         m_pressed = 0;
    bit         m_extended = 0;

    task automatic model_byte(input logic [7:0] b, input bit valid,
                              output int exp_s, output int exp_e);
        exp_s = 0;
        exp_e = 0;
        if (!valid) begin
            exp_e = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
            m_ext = 0;
            m_brk = 0;
        end else begin
            exp_s      = 1;
            m_code     = b;
            m_pressed  = !m_brk;
            m_extended = m_ext;
            m_ext      = 0;
            m_brk      = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_strobe = 0;
        n_err    = 0;
        wide     = 0;
        both     = 0;
    endtask

    // Drive nbits bits (bit 0 first), one falling ps2Clk per bit.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps2Data = bits[i];
            repeat (HALF) @(negedge clock);
            ps2Clk   = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clock);
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit flip, input bit stop);
        logic par;
        par = ~(^b) ^ flip;
        return {stop, par, b, 1'b0};
    endfunction

    task automatic check_frame(input string tag, input int exp_s, input int exp_e);
        chk({tag, ".strobes"}, n_strobe, exp_s);
        chk({tag, ".errors"}, n_err, exp_e);
        chk({tag, ".pulse_wide"}, {31'd0, wide}, 0);
        chk({tag, ".strobe_and_error"}, {31'd0, both}, 0);
        chk({tag, ".code"}, {24'd0, code}, {24'd0, m_code});
        chk({tag, ".pressed"}, {31'd0, pressed}, {31'd0, m_pressed});
        chk({tag, ".extended"}, {31'd0, extended}, {31'd0, m_extended});
        if (exp_s == 1) chk({tag, ".latency"}, strobe_cyc - fall_cyc, FILTER + 2);
        $display("frame %s: strobes=%0d errors=%0d code=%02h pressed=%0b extended=%0b",
                 tag, n_strobe, n_err, code, pressed, extended);
        clear_mon();
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input bit flip, input bit stop);
        int es, ee;
        send_bits(make_frame(b, flip, stop), 11);
        repeat (2 * HALF) @(negedge clock);
        model_byte(b, !flip && stop, es, ee);
        check_frame(tag, es, ee);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".strobe"}, {31'd0, strobe}, 0);
        chk({tag, ".error"}, {31'd0, error}, 0);
        chk({tag, ".pressed"}, {31'd0, pressed}, 0);
        chk({tag, ".extended"}, {31'd0, extended}, 0);
        chk({tag, ".code"}, {24'd0, code}, 0);
        $display("reset %s: strobe=%0b error=%0b pressed=%0b extended=%0b code=%02h",
                 tag, strobe, error, pressed, extended, code);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rflip, rstop;
        int         sel;

        reset   = 1'b0;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        repeat (5) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b1;
        repeat (5) @(negedge clock);
        clear_mon();

        // Plain make code
        run_frame("make_1C", 8'h1C, 0, 1);

        // Break sequence, then make again
        run_frame("brk_F0", 8'hF0, 0, 1);
        run_frame("brk_1C", 8'h1C, 0, 1);
        run_frame("make_1C_again", 8'h1C, 0, 1);

        // Extended break sequence, then plain make
        run_frame("ext_E0", 8'hE0, 0, 1);
        run_frame("ext_F0", 8'hF0, 0, 1);
        run_frame("ext_75", 8'h75, 0, 1);
        run_frame("plain_75", 8'h75, 0, 1);

        // Bad parity, bad stop bit
        run_frame("bad_parity", 8'h1C, 1, 1);
        run_frame("bad_stop", 8'h3A, 0, 0);

        // Ignored device byte clears a pending prefix
        run_frame("pre_F0", 8'hF0, 0, 1);
        run_frame("ack_FA", 8'hFA, 0, 1);
        run_frame("after_ack", 8'h2B, 0, 1);

        // Aborted partial frame: prefix kept, no error across the gap
        run_frame("tmo_F0", 8'hF0, 0, 1);
        send_bits(make_frame(8'h29, 0, 1), 5);
        repeat (TIMEOUT + 10) @(negedge clock);
        check_frame("tmo_gap", 0, 0);
        run_frame("tmo_29", 8'h29, 0, 1);

        // Short clock glitch with data low must not start a frame
        @(negedge clock);
        ps2Data = 1'b0;
        ps2Clk  = 1'b0;
        repeat (FILTER - 1) @(negedge clock);
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        repeat (2 * HALF) @(negedge clock);
        check_frame("glitch", 0, 0);
        run_frame("glitch_1C", 8'h1C, 0, 1);

        // Reset after the 5th data bit of a frame
        run_frame("rst_pre_E0", 8'hE0, 0, 1);
        send_bits(make_frame(8'h5A, 0, 1), 6);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("mid_frame");
        reset = 1'b1;
        m_ext = 0; m_brk = 0; m_code = 8'h00; m_pressed = 0; m_extended = 0;
        repeat (5) @(negedge clock);
        check_reset_outputs("post_release");
        clear_mon();
        run_frame("rst_1C", 8'h1C, 0, 1);

        // Randomized byte stream
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: rb = 8'hE0;
                1: rb = 8'hF0;
                2: begin
                    case ($urandom_range(0, 5))
                        0: rb = 8'hFA;
                        1: rb = 8'hAA;
                        2: rb = 8'hEE;
                        3: rb = 8'hFE;
                        4: rb = 8'h00;
                        default: rb = 8'hFF;
                    endcase
                end
                default: rb = 8'($urandom_range(0, 255));
            endcase
            sel   = $urandom_range(0, 9);
            rflip = (sel == 0);
            rstop = (sel != 1);
            run_frame($sformatf("rnd%0d_%02h", i, rb), rb, rflip, rstop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter FILTER, default 8: clock cycles a synchronized ps2Clk level must hold before it is accepted.
REQ-002 SHALL have parameter TIMEOUT, default 50000: clock cycles without an accepted falling edge before a partial frame is aborted.
REQ-003 SHALL have port clock, input, 1: single system clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2Clk, input, 1: raw PS/2 clock line from the pad, asynchronous.
REQ-006 SHALL have port ps2Data, input, 1: raw PS/2 data line from the pad, asynchronous.
REQ-007 SHALL have port strobe, output, 1: one-cycle pulse marking a new key event.
REQ-008 SHALL have port pressed, output, 1: 1 = make, 0 = break; valid from strobe, held until the next strobe.
REQ-009 SHALL have port code, output, 8: scan code; valid from strobe, held until the next strobe.
REQ-010 SHALL have port extended, output, 1: event was preceded by E0; valid from strobe, held until the next strobe.
REQ-011 SHALL have port error, output, 1: one-cycle pulse on a parity or stop-bit failure.

Function
REQ-012 SHALL pass ps2Clk and ps2Data each through a 2-flop synchronizer.
REQ-013 SHALL update the filtered clock only after the synchronized ps2Clk has held a new level for FILTER consecutive cycles.
REQ-014 SHALL sample synchronized ps2Data in the cycle where the filtered clock goes 1->0 ("edge").
REQ-015 SHALL use FSM states IDLE, DATA, PARITY, STOP.
REQ-016 SHALL, in IDLE: on an edge with data 0, go to DATA and clear the bit count; on an edge with data 1, stay in IDLE with no other effect.
REQ-017 SHALL, in DATA: shift in 8 bits LSB first, one per edge; go to PARITY after the 8th.
REQ-018 SHALL, in PARITY: on an edge, latch the parity bit and go to STOP.
REQ-019 SHALL, in STOP: on an edge, return to IDLE; the frame is valid when the stop bit is 1 and the 8 data bits plus parity hold an odd number of ones.
REQ-020 SHALL, for an invalid frame, pulse error for one cycle at edge+1, suppress strobe, and leave the prefix flags unchanged.
REQ-021 SHALL, for a valid frame with byte E0, set the ext flag and not strobe.
REQ-022 SHALL, for a valid frame with byte F0, set the brk flag and not strobe.
REQ-023 SHALL, for a valid frame with byte FA, AA, EE, FE, 00 or FF, not strobe and clear both flags.
REQ-024 SHALL, for any other valid byte, assert strobe exactly one cycle at edge+1 with code = byte, pressed = !brk, extended = ext, and clear both flags in the same cycle.
REQ-025 SHALL run a timeout counter in every state except IDLE, cleared on each edge; when it reaches TIMEOUT, the FSM goes to IDLE, the partial byte is discarded, no strobe or error is produced, and the prefix flags are kept.
REQ-026 SHALL cap the timeout counter width at ceil(log2(TIMEOUT+1)) bits, with no wrap before the compare.
REQ-027 SHALL keep strobe and error mutually exclusive; a timeout coinciding with an edge resolves in favour of the edge.
REQ-028 SHALL ignore ps2Clk and ps2Data otherwise; the block never drives the PS/2 lines.

Reset
REQ-029 SHALL, with reset low, force: FSM = IDLE; strobe, error, pressed, extended = 0; code = 00; ext, brk = 0; bit count and timeout = 0; filtered clock = 1; synchronizers = 1.
REQ-030 SHALL, on reset asserted mid-frame, discard the frame; the first frame after release is decoded normally.

Verification
REQ-031 SHALL cover: frame 1C (parity 0, stop 1) -> one strobe at edge+1 with code=1C, pressed=1, extended=0.
REQ-032 SHALL cover: frames F0, 1C -> exactly one strobe with code=1C, pressed=0; then frame 1C -> pressed=1.
REQ-033 SHALL cover: frames E0, F0, 75 -> one strobe with code=75, pressed=0, extended=1; the next frame 75 gives extended=0.
REQ-034 SHALL cover: frame 1C with flipped parity -> error pulse of 1 cycle, no strobe, code still holds its previous value.
REQ-035 SHALL cover: start plus 4 data bits, then an idle clock for TIMEOUT+10 cycles, then frame 29 -> no error during the gap, then strobe with code=29.
REQ-036 SHALL cover: ps2Clk glitch low for FILTER-1 cycles in IDLE -> no state change; reset pulsed after the 5th bit of a frame -> all outputs 0 and the next frame decodes correctly.
